// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with a circular hardware return stack.
// Overflow overwrites the oldest entry; both error flags are sticky until cleared.
module pc_stack_unit #(
    parameter int                  PC_WIDTH     = 10,
    parameter int                  SP_WIDTH     = 3,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(4)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                int_en,
    input  logic                goto_en,
    input  logic                call_en,
    input  logic                ret_en,
    input  logic                jump_en,
    input  logic                skip_en,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                clear_flags,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] stack_top,
    output logic [SP_WIDTH-1:0] sp,
    output logic [SP_WIDTH:0]   depth,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    localparam int                DEPTH      = 2 ** SP_WIDTH;
    localparam logic [SP_WIDTH:0] DEPTH_FULL = (SP_WIDTH + 1)'(DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [SP_WIDTH-1:0] sp_q, sp_d;
    logic [SP_WIDTH:0]   depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PC_WIDTH-1:0] stack_q [DEPTH];
    logic [PC_WIDTH-1:0] stack_d [DEPTH];

    logic [SP_WIDTH-1:0] sp_prev;
    logic                do_push;
    logic                do_pop;
    logic [PC_WIDTH-1:0] push_val;

    assign sp_prev = sp_q - 1'b1;

    // One action per edge, highest priority first.
    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_val = pc_q;
        pc_d     = pc_q;
        if (en) begin
            if (int_en) begin
                do_push  = 1'b1;
                push_val = pc_q;
                pc_d     = INT_VECTOR;
            end else if (goto_en) begin
                pc_d = target;
            end else if (call_en) begin
                do_push  = 1'b1;
                push_val = pc_q + 1'b1;
                pc_d     = target;
            end else if (ret_en) begin
                do_pop = 1'b1;
                pc_d   = stack_q[sp_prev];
            end else if (jump_en) begin
                pc_d = target;
            end else if (skip_en) begin
                pc_d = pc_q + PC_WIDTH'(2);
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    // Clear is applied first so a same-edge error still sets the flag.
    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        ovf_d   = clear_flags ? 1'b0 : ovf_q;
        unf_d   = clear_flags ? 1'b0 : unf_q;
        if (do_push) begin
            stack_d[sp_q] = push_val;
            sp_d          = sp_q + 1'b1;
            if (depth_q == DEPTH_FULL) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 1'b1;
            end
        end else if (do_pop) begin
            sp_d = sp_prev;
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            stack_q <= stack_d;
        end
    end

    assign pc              = pc_q;
    assign stack_top       = stack_q[sp_prev];
    assign sp              = sp_q;
    assign depth           = depth_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
